// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
package ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    // ALU operation codes (full 3-bit form, truncated at the port)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    // Data-processing cmd field values
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Instruction class (Op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA encodings
    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Condition field codes
    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT,
        COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    // Evaluate a condition code against an {N,Z,C,V} flag vector
    function automatic logic cond_holds(input cond_t c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return cf;
            COND_CC: return ~cf;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return cf & ~z;
            COND_LS: return ~cf | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_logic.sv
// Architectural NZCV register, condition evaluation and write-enable gating.
module cond_logic
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_latch_cond,
    input  logic [1:0] i_flag_w,
    input  logic       i_fetch,
    input  logic       i_branch,
    input  logic       i_reg_w,
    input  logic       i_mem_w,
    input  logic       i_rd_is_pc,
    output logic [3:0] o_flags,
    output logic       o_pc_write,
    output logic       o_reg_write,
    output logic       o_mem_write
);

    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic       w_cond_ex;

    assign w_cond_ex = cond_holds(cond_t'(i_cond), r_flags);

    // Latch the condition in DECODE; update flag halves at the end of execute when the condition held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
        end else begin
            if (i_latch_cond)
                r_cond_ex <= w_cond_ex;
            if (i_flag_w[1] & r_cond_ex)
                r_flags[3:2] <= i_alu_flags[3:2];
            if (i_flag_w[0] & r_cond_ex)
                r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

    assign o_flags     = r_flags;
    assign o_reg_write = i_reg_w & r_cond_ex & ~reset;
    assign o_mem_write = i_mem_w & r_cond_ex & ~reset;
    assign o_pc_write  = (i_fetch | ((i_branch | (i_reg_w & i_rd_is_pc)) & r_cond_ex)) & ~reset;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore sequencer, instruction decode and ALU op selection.
// ALUCTRL_W is 2 (no EOR) or 3; EN_CMP enables the flag-only compare/test ops.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit EN_CMP    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           Cond,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags,
    output logic                 Undef
);

    state_t     r_state;
    logic       w_dp_legal, w_flag_only, w_arith, w_legal;
    logic [2:0] w_dp_op, w_alu_full;
    logic       w_fetch, w_latch, w_reg_w, w_mem_w, w_branch, w_exec;
    logic [1:0] w_flag_w;
    logic       w_s;

    // Data-processing decode from the cmd field
    always_comb begin
        w_dp_legal  = 1'b1;
        w_flag_only = 1'b0;
        w_arith     = 1'b0;
        w_dp_op     = ALU_ADD;
        case (Funct[4:1])
            CMD_ADD: begin w_dp_op = ALU_ADD; w_arith = 1'b1; end
            CMD_SUB: begin w_dp_op = ALU_SUB; w_arith = 1'b1; end
            CMD_AND: w_dp_op = ALU_AND;
            CMD_ORR: w_dp_op = ALU_ORR;
            CMD_EOR: begin w_dp_op = ALU_EOR; w_dp_legal = (ALUCTRL_W >= 3); end
            CMD_CMP: begin w_dp_op = ALU_SUB; w_arith = 1'b1; w_flag_only = 1'b1; w_dp_legal = EN_CMP; end
            CMD_CMN: begin w_dp_op = ALU_ADD; w_arith = 1'b1; w_flag_only = 1'b1; w_dp_legal = EN_CMP; end
            CMD_TST: begin w_dp_op = ALU_AND; w_flag_only = 1'b1; w_dp_legal = EN_CMP; end
            default: w_dp_legal = 1'b0;
        endcase
    end

    assign w_legal = (Op == OP_MEM) | (Op == OP_BR) | ((Op == OP_DP) & w_dp_legal);

    // State sequencing; an asynchronous reset aborts the current instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_legal)           r_state <= S_FETCH;
                    else if (Op == OP_MEM)  r_state <= S_MEMADR;
                    else if (Op == OP_BR)   r_state <= S_BRANCH;
                    else if (Funct[5])      r_state <= S_EXECI;
                    else                    r_state <= S_EXECR;
                end
                S_MEMADR: r_state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECR,
                S_EXECI:  r_state <= w_flag_only ? S_FETCH : S_ALUWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode from the current state
    always_comb begin
        w_fetch   = 1'b0;
        w_latch   = 1'b0;
        w_reg_w   = 1'b0;
        w_mem_w   = 1'b0;
        w_branch  = 1'b0;
        w_exec    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        case (r_state)
            S_FETCH: begin
                w_fetch = 1'b1; ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                w_latch = 1'b1; ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_EXTIMM;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB:  begin ResultSrc = RES_DATA; w_reg_w = 1'b1; end
            S_MEMWR:  begin AdrSrc = 1'b1; w_mem_w = 1'b1; end
            S_EXECR:  w_exec = 1'b1;
            S_EXECI:  begin w_exec = 1'b1; ALUSrcB = SRCB_EXTIMM; end
            S_ALUWB:  w_reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_ALUOUT; ALUSrcB = SRCB_EXTIMM; ResultSrc = RES_ALURESULT; w_branch = 1'b1;
            end
            default:  w_fetch = 1'b0;
        endcase
    end

    // Compare/test ops always set flags; carry/overflow only come from add/subtract forms
    assign w_s        = Funct[0] | w_flag_only;
    assign w_flag_w   = {w_exec & w_s, w_exec & w_s & w_arith};
    assign w_alu_full = w_exec ? w_dp_op : ALU_ADD;
    assign ALUControl = w_alu_full[ALUCTRL_W-1:0];
    assign IRWrite    = w_fetch & ~reset;
    assign Undef      = (r_state == S_DECODE) & ~w_legal;
    assign ImmSrc     = (Op == 2'b11) ? 2'b00 : Op;
    assign RegSrc     = {(Op == OP_MEM) & ~Funct[0], Op == OP_BR};

    cond_logic u_cond (
        .clk          (clk),
        .reset        (reset),
        .i_cond       (Cond),
        .i_alu_flags  (ALUFlags),
        .i_latch_cond (w_latch),
        .i_flag_w     (w_flag_w),
        .i_fetch      (w_fetch),
        .i_branch     (w_branch),
        .i_reg_w      (w_reg_w),
        .i_mem_w      (w_mem_w),
        .i_rd_is_pc   (Rd == 4'hF),
        .o_flags      (Flags),
        .o_pc_write   (PCWrite),
        .o_reg_write  (RegWrite),
        .o_mem_write  (MemWrite)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against a per-instruction cycle-trace model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd, Cond, ALUFlags;

    logic       pcw_a, irw_a, rw_a, mw_a, adr_a, und_a;
    logic [1:0] res_a, sa_a, sb_a, imm_a, rs_a;
    logic [2:0] alu_a;
    logic [3:0] fl_a;
    logic       pcw_b, irw_b, rw_b, mw_b, adr_b, und_b;
    logic [1:0] res_b, sa_b, sb_b, imm_b, rs_b;
    logic [1:0] alu_b;
    logic [3:0] fl_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic        sel;
    logic [18:0] obs_w;
    logic [3:0]  obs_fl;

    // Reference model state
    logic [3:0] m_flags;
    bit         m_en_cmp;
    int         m_aw;

    always #5 clk = ~clk;

    multicycle_controller #(.ALUCTRL_W(3), .EN_CMP(1'b1)) dut (
        .clk(clk), .reset(rst_a), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond), .ALUFlags(ALUFlags),
        .PCWrite(pcw_a), .IRWrite(irw_a), .RegWrite(rw_a), .MemWrite(mw_a), .AdrSrc(adr_a),
        .ResultSrc(res_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a), .RegSrc(rs_a),
        .ALUControl(alu_a), .Flags(fl_a), .Undef(und_a)
    );

    multicycle_controller #(.ALUCTRL_W(2), .EN_CMP(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond), .ALUFlags(ALUFlags),
        .PCWrite(pcw_b), .IRWrite(irw_b), .RegWrite(rw_b), .MemWrite(mw_b), .AdrSrc(adr_b),
        .ResultSrc(res_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b), .RegSrc(rs_b),
        .ALUControl(alu_b), .Flags(fl_b), .Undef(und_b)
    );

    always_comb begin
        if (sel) begin
            obs_w  = {und_b, pcw_b, irw_b, rw_b, mw_b, adr_b, res_b, sa_b, sb_b, {1'b0, alu_b}, imm_b, rs_b};
            obs_fl = fl_b;
        end else begin
            obs_w  = {und_a, pcw_a, irw_a, rw_a, mw_a, adr_a, res_a, sa_a, sb_a, alu_a, imm_a, rs_a};
            obs_fl = fl_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [18:0] cw(input bit und, input bit pcw, input bit irw, input bit rw,
                                       input bit mw, input bit adr, input logic [1:0] res,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [1:0] imm,
                                       input logic [1:0] rs);
        return {und, pcw, irw, rw, mw, adr, res, sa, sb, alu, imm, rs};
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Build the expected cycle trace of one instruction, drive it, and compare every cycle.
    // Called #1 after the edge that entered FETCH.
    task automatic run_instr(input string nm, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input logic [3:0] cond, input logic [3:0] af);
        logic [18:0] q[$];
        bit legal, fonly, arith, ce, rdpc, s;
        logic [2:0] aop;
        logic [1:0] imm, rs;
        legal = 1; fonly = 0; arith = 0; aop = 3'd0;
        case (fn[4:1])
            4'b0100: begin aop = 3'd0; arith = 1; end
            4'b0010: begin aop = 3'd1; arith = 1; end
            4'b0000: aop = 3'd2;
            4'b1100: aop = 3'd3;
            4'b0001: begin aop = 3'd4; legal = (m_aw >= 3); end
            4'b1010: begin aop = 3'd1; arith = 1; fonly = 1; legal = m_en_cmp; end
            4'b1011: begin aop = 3'd0; arith = 1; fonly = 1; legal = m_en_cmp; end
            4'b1000: begin aop = 3'd2; fonly = 1; legal = m_en_cmp; end
            default: legal = 0;
        endcase
        if (op == 2'd1 || op == 2'd2) legal = 1;
        if (op == 2'd3) legal = 0;
        if (m_aw == 2) aop = aop & 3'b011;
        imm  = (op == 2'd3) ? 2'd0 : op;
        rs   = {op == 2'd1 && !fn[0], op == 2'd2};
        ce   = cond_ok(cond, m_flags);
        rdpc = (rd == 4'hF);
        q.push_back(cw(0, 1, 1, 0, 0, 0, 2'd2, 2'd1, 2'd2, 3'd0, imm, rs));
        q.push_back(cw(!legal, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 3'd0, imm, rs));
        if (legal) begin
            if (op == 2'd1) begin
                q.push_back(cw(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, imm, rs));
                if (fn[0]) begin
                    q.push_back(cw(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, imm, rs));
                    q.push_back(cw(0, ce && rdpc, 0, ce, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, imm, rs));
                end else begin
                    q.push_back(cw(0, 0, 0, 0, ce, 1, 2'd0, 2'd0, 2'd0, 3'd0, imm, rs));
                end
            end else if (op == 2'd2) begin
                q.push_back(cw(0, ce, 0, 0, 0, 0, 2'd2, 2'd2, 2'd1, 3'd0, imm, rs));
            end else begin
                q.push_back(cw(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, fn[5] ? 2'd1 : 2'd0, aop, imm, rs));
                if (!fonly)
                    q.push_back(cw(0, ce && rdpc, 0, ce, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, imm, rs));
            end
        end
        Op = op; Funct = fn; Rd = rd; Cond = cond; ALUFlags = af;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            chk($sformatf("%s.cyc%0d", nm, k), {13'd0, obs_w}, {13'd0, q[k]});
            @(posedge clk);
            #1;
        end
        if (legal && op == 2'd0 && ce) begin
            s = fn[0] || fonly;
            if (s) m_flags[3:2] = af[3:2];
            if (s && arith) m_flags[1:0] = af[1:0];
        end
        chk({nm, ".flags"}, {28'd0, obs_fl}, {28'd0, m_flags});
    endtask

    task automatic rand_instr(input string nm);
        logic [1:0] op;
        logic [3:0] cmd, cond, rd;
        int r;
        logic [3:0] cmds [8];
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1011, 4'b1000};
        r  = $urandom_range(0, 9);
        op = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        cmd  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : cmds[$urandom_range(0, 7)];
        cond = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
        rd   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        run_instr(nm, op, {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))}, rd, cond,
                  4'($urandom_range(0, 15)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; m_flags = 4'd0; m_en_cmp = 1; m_aw = 3;
        rst_a = 1'b1; rst_b = 1'b1;
        Op = 2'd0; Funct = 6'd0; Rd = 4'd0; Cond = 4'd14; ALUFlags = 4'd0;
        #1;
        chk("rst.pcw", {31'd0, pcw_a}, 32'd0);
        chk("rst.irw", {31'd0, irw_a}, 32'd0);
        chk("rst.flags", {28'd0, fl_a}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_a = 1'b0;

        // Directed sequence
        run_instr("add_imm", 2'b00, 6'b101000, 4'd3, 4'b1110, 4'b1111);
        run_instr("subs",    2'b00, 6'b000101, 4'd1, 4'b1110, 4'b0110);
        run_instr("beq",     2'b10, 6'b000000, 4'd0, 4'b0000, 4'b0000);
        run_instr("ldr_pc",  2'b01, 6'b011001, 4'hF, 4'b1110, 4'b0000);
        run_instr("cmp",     2'b00, 6'b010101, 4'd0, 4'b1110, 4'b0100);
        run_instr("str_ne",  2'b01, 6'b011000, 4'd2, 4'b0001, 4'b0000);
        run_instr("eor",     2'b00, 6'b000010, 4'd4, 4'b1110, 4'b1000);
        run_instr("undef11", 2'b11, 6'b000000, 4'd0, 4'b1110, 4'b0000);
        run_instr("subs_pc", 2'b00, 6'b100101, 4'hF, 4'b1110, 4'b1001);

        // Reset in the middle of a store
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd2; Cond = 4'b1110; ALUFlags = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("memwr.mw", {31'd0, mw_a}, 32'd1);
        #2 rst_a = 1'b1;
        #1;
        chk("abort.mw", {31'd0, mw_a}, 32'd0);
        chk("abort.pcw", {31'd0, pcw_a}, 32'd0);
        chk("abort.irw", {31'd0, irw_a}, 32'd0);
        @(posedge clk); #1;
        chk("abort.flags", {28'd0, fl_a}, 32'd0);
        rst_a = 1'b0;
        m_flags = 4'd0;
        #1;
        chk("release.irw", {31'd0, irw_a}, 32'd1);
        chk("release.srca", {30'd0, sa_a}, 32'd1);

        for (int i = 0; i < 150; i++) rand_instr($sformatf("rnd%0d", i));

        // Reduced variant: no EOR, no compare/test
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b0; sel = 1'b1;
        m_flags = 4'd0; m_en_cmp = 0; m_aw = 2;
        run_instr("b.cmp",  2'b00, 6'b010101, 4'd0, 4'b1110, 4'b0100);
        run_instr("b.eor",  2'b00, 6'b000010, 4'd4, 4'b1110, 4'b1000);
        run_instr("b.orrs", 2'b00, 6'b111001, 4'd5, 4'b1110, 4'b1011);
        run_instr("b.subs", 2'b00, 6'b000101, 4'd1, 4'b1110, 4'b0110);
        for (int i = 0; i < 40; i++) rand_instr($sformatf("rndb%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle ARM control unit; successor to the single-cycle main/ALU decoder.
- Sequences each instruction through a Moore FSM, adds conditional execution with an internal NZCV flags register, and extends the ALU op set.
- Sits between the instruction register and the multicycle datapath, driving mux selects and write enables each cycle.

Parameters:
- ALUCTRL_W, 3, ALUControl width. 2 gives ADD/SUB/AND/ORR only; 3 adds EOR.
- EN_CMP, 1, 1 enables CMP/CMN/TST (flag-only, no writeback). 0 makes them illegal.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Op  in  2  instr[27:26].
- Funct  in  6  instr[25:20]: {I, cmd[3:0], S/L}.
- Rd  in  4  instr[15:12].
- Cond  in  4  instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  memory write enable.
- AdrSrc  out  1  0=PC, 1=ALUOut.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  00=RD1, 01=PC, 10=ALUOut.
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4.
- ImmSrc  out  2  Op-driven: 00 DP, 01 mem, 10 branch.
- RegSrc  out  2  {STR, B} select.
- ALUControl  out  ALUCTRL_W  ALU op.
- Flags  out  4  architectural NZCV register.
- Undef  out  1  one-cycle pulse in DECODE for an illegal instruction.

Behaviour:
- Reset, asynchronous:
  - state=FETCH, Flags=0000, CondExR=0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced 0 while reset is high.
  - Reset asserted mid-instruction aborts it with no further writes.
- FSM states and outputs (Moore; unlisted selects are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALU add, PCWrite=1. Next state DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALU add. Latches CondExR.
    - Op=01 -> MEMADR.
    - Op=00 and legal -> EXECUTER if I=0, EXECUTEI if I=1.
    - Op=10 -> BRANCH.
    - Illegal -> FETCH with Undef=1.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, add. L=1 -> MEMRD; L=0 -> MEMWR.
  - MEMRD: AdrSrc=1 -> MEMWB.
  - MEMWB: ResultSrc=01, RegW -> FETCH.
  - MEMWR: AdrSrc=1, MemW -> FETCH.
  - EXECUTER (ALUSrcB=00) / EXECUTEI (ALUSrcB=01): ALUSrcA=00, decoded op. Flag-only op -> FETCH; otherwise -> ALUWB.
  - ALUWB: ResultSrc=00, RegW -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, add, Branch -> FETCH.
- Latency in cycles: DP 4, CMP/CMN/TST 3, LDR 5, STR 4, B 3.
- ALU decode on cmd=Funct[4:1]:
  - 0100 ADD=000, 0010 SUB=001, 0000 AND=010, 1100 ORR=011, 0001 EOR=100 (ALUCTRL_W=3 only).
  - 1010 CMP=001, 1011 CMN=000, 1000 TST=010: flag-only, and only when EN_CMP=1.
  - Any other cmd, or Op=11, is illegal.
  - Non-DP states use add. ALUControl is truncated to ALUCTRL_W.
- Conditional execution:
  - CondEx is evaluated combinationally in DECODE from Cond and Flags, then registered as CondExR.
  - Cond table: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
  - Gating:
    - RegWrite = RegW & CondExR.
    - MemWrite = MemW & CondExR.
    - PCWrite = FETCH | ((Branch | (RegW & Rd==15)) & CondExR).
- Flag update, at the clock edge ending EXECUTER/EXECUTEI, only if CondExR:
  - NZ <- ALUFlags[3:2] when S=1.
  - CV <- ALUFlags[1:0] when S=1 and the op is ADD/SUB/CMP/CMN.
  - CMP/CMN/TST force S=1.
- Simultaneous-event rule: an instruction's condition is checked against flags as they stood before its own update.

Decomposition:
- ctrl_pkg holds:
  - the state enum (10 states);
  - ALU op constants;
  - ResultSrc/ALUSrcA/ALUSrcB encodings;
  - the Cond code enum.
- cond_logic sub-module holds the Flags register, the CondEx evaluation, the CondExR register and the flag-write gating.
- The FSM plus instruction decode stay in multicycle_controller.

Test Plan:
- Reset pulse mid-MEMWR -> MemWrite drops to 0 immediately; after release, state=FETCH, Flags=0000, IRWrite=1.
- ADD imm, Op=00, Funct=101000, Cond=1110 -> 4 cycles; ALUWB has RegWrite=1, ALUControl=000; Flags unchanged.
- SUBS reg, Funct=000101, ALUFlags=0110 -> Flags=0110 after EXECUTER; then BEQ (Op=10, Cond=0000) -> PCWrite=1 in BRANCH.
- LDR, Op=01, Funct=011001, Rd=15 -> 5 cycles; PCWrite=1 and RegWrite=1 in MEMWB.
- CMP, Funct=010101, EN_CMP=1 -> 3 cycles with no RegWrite. With EN_CMP=0 -> Undef pulse in DECODE and return to FETCH.
- STR with Cond=0001 while Z=1 -> MEMWR cycle has MemWrite=0; EOR (cmd 0001) with ALUCTRL_W=2 -> Undef.
